// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bus of the sequential signed divider.
interface seq_signed_divider_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         divzero;
  logic         ovflag;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, divzero, ovflag
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, divzero, ovflag
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: sign-magnitude restoring division, one step per clock.
module seq_signed_divider #(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_signed_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_DIVZ, SP_OVF} special_t;

  state_t   state_q, state_d;
  special_t special_q, special_d, special_in;

  logic          neg_dvd_q, neg_dvd_d;
  logic          neg_dsr_q, neg_dsr_d;
  // magnitude dividend; quotient bits shift in from the LSB during CALC
  logic [N-1:0]  mag_dvd_q, mag_dvd_d;
  logic [N-1:0]  mag_dsr_q, mag_dsr_d;
  logic [N-1:0]  prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic [N:0]    shifted;
  logic [N:0]    trial;

  function automatic logic [N-1:0] negate(input logic [N-1:0] x);
    return (~x) + N'(1);
  endfunction

  function automatic logic [N-1:0] abs_val(input logic [N-1:0] x);
    return x[N-1] ? negate(x) : x;
  endfunction

  // Partial remainder is below |divisor| <= 2^(N-1), so the shifted value fits N+1 bits
  assign shifted = {prem_q, mag_dvd_q[N-1]};
  assign trial   = shifted - {1'b0, mag_dsr_q};

  // Classify operands that bypass the iterative path
  always_comb begin
    special_in = SP_NONE;
    if (bus.divisor == '0) begin
      special_in = SP_DIVZ;
    end else if ((bus.dividend == MOST_NEG) && (bus.divisor == '1)) begin
      special_in = SP_OVF;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (special_in == SP_NONE) ? CALC : FIX;
        end
      end
      CALC: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    special_d = special_q;
    neg_dvd_d = neg_dvd_q;
    neg_dsr_d = neg_dsr_q;
    mag_dvd_d = mag_dvd_q;
    mag_dsr_d = mag_dsr_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          special_d = special_in;
          neg_dvd_d = bus.dividend[N-1];
          neg_dsr_d = bus.divisor[N-1];
          mag_dvd_d = abs_val(bus.dividend);
          mag_dsr_d = abs_val(bus.divisor);
          prem_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        if (!trial[N]) begin
          prem_d    = trial[N-1:0];
          mag_dvd_d = {mag_dvd_q[N-2:0], 1'b1};
        end else begin
          prem_d    = shifted[N-1:0];
          mag_dvd_d = {mag_dvd_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        case (special_q)
          SP_DIVZ: begin
            quo_d = '1;
            // magnitude and sign reconstruct the original dividend, including MOST_NEG
            rem_d = neg_dvd_q ? negate(mag_dvd_q) : mag_dvd_q;
            dz_d  = 1'b1;
            ov_d  = 1'b0;
          end
          SP_OVF: begin
            quo_d = MOST_NEG;
            rem_d = '0;
            dz_d  = 1'b0;
            ov_d  = 1'b1;
          end
          default: begin
            quo_d = (neg_dvd_q ^ neg_dsr_q) ? negate(mag_dvd_q) : mag_dvd_q;
            rem_d = neg_dvd_q ? negate(prem_q) : prem_q;
            dz_d  = 1'b0;
            ov_d  = 1'b0;
          end
        endcase
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      special_q <= SP_NONE;
      neg_dvd_q <= 1'b0;
      neg_dsr_q <= 1'b0;
      mag_dvd_q <= '0;
      mag_dsr_q <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      special_q <= special_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dsr_q <= neg_dsr_d;
      mag_dvd_q <= mag_dvd_d;
      mag_dsr_q <= mag_dsr_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.divzero   = dz_q;
  assign bus.ovflag    = ov_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (N=32) using directed vectors.
module tb_seq_signed_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int unsigned lat;
    int unsigned acc;
    int          id;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int unsigned lat;
  } vec_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          n_vec;
  int          n_fail;
  int          next_id;
  exp_t        sb[$];
  vec_t        vecs[14];

  seq_signed_divider_if #(.N(32)) bus ();

  seq_signed_divider #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
    end
  endtask

  // Called at a negedge: presents one start pulse, optionally records the expected result
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic push,
                        input logic [31:0] q, input logic [31:0] r, input logic dz,
                        input logic ov, input int unsigned lat);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat;
      e.acc = cyc + 1;
      e.id  = next_id;
      next_id++;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops and compares whenever the DUT pulses done
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          e = sb.pop_front();
          check("quotient", e.id, bus.quotient, e.q);
          check("remainder", e.id, bus.remainder, e.r);
          check("divzero", e.id, {31'b0, bus.divzero}, {31'b0, e.dz});
          check("ovflag", e.id, {31'b0, bus.ovflag}, {31'b0, e.ov});
          check("latency", e.id, 32'(cyc - e.acc), 32'(e.lat));
          check("done_single_cycle", e.id, {31'b0, prev_done}, 32'h0);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit found;
    clk = 1'b0; cyc = 0; n_vec = 0; n_fail = 0; next_id = 0;
    rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    //            dividend      divisor       quotient      remainder     dz    ov    lat
    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 33};
    vecs[4]  = '{32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b1, 1'b0, 1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1};
    vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 1'b0, 33};
    vecs[7]  = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1};
    vecs[8]  = '{32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
    vecs[9]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 33};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 1'b0, 33};
    vecs[11] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0, 33};
    vecs[12] = '{32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
    vecs[13] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 1'b0, 33};

    repeat (3) @(negedge clk);
    check("reset_busy", -1, {31'b0, bus.busy}, 32'h0);
    check("reset_done", -1, {31'b0, bus.done}, 32'h0);
    check("reset_flags", -1, {30'b0, bus.divzero, bus.ovflag}, 32'h0);
    check("reset_quotient", -1, bus.quotient, 32'h0);
    check("reset_remainder", -1, bus.remainder, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov, vecs[i].lat);
      wait_drain();
    end

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    launch(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, 1'b0, 33);
    repeat (5) @(negedge clk);
    launch(32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", -1, {31'b0, found}, 32'h1);
    launch(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0, 33);
    check("done_drops_on_restart", -1, {31'b0, bus.done}, 32'h0);
    check("busy_after_restart", -1, {31'b0, bus.busy}, 32'h1);
    wait_drain();

    // Load a result with a nonzero remainder, then abort a later operation with rst
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 33);
    wait_drain();
    @(negedge clk);
    launch(32'hFFFFFF9C, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    check("busy_mid_calc", -1, {31'b0, bus.busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", -1, {31'b0, bus.busy}, 32'h0);
    check("abort_done", -1, {31'b0, bus.done}, 32'h0);
    check("abort_flags", -1, {30'b0, bus.divzero, bus.ovflag}, 32'h0);
    check("abort_quotient", -1, bus.quotient, 32'h0);
    check("abort_remainder", -1, bus.remainder, 32'h0);
    repeat (45) @(negedge clk);

    // Recovery after abort
    @(negedge clk);
    launch(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
